eth_tx_framer: RTL and testbench



---
 rtl/eth_tx_framer.sv | 199 +++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: preamble/SFD insertion, optional short-frame padding, FCS append and IFG.
// Optional feature macro: ETH_TX_PAD_EN enables zero-padding of short frames to MIN_FRAME_BYTES.

package ethernet_pkg;
    localparam int unsigned N_OF_BYTE_FRAME_MAX  = 1526;
    localparam int unsigned N_OF_BYTE_FCS        = 4;
    localparam int unsigned FRAME_SIZE_BIT_WIDTH = 11;
    localparam logic [7:0]  PREAMBLE_BYTE        = 8'hAA;
    localparam logic [7:0]  SFD_BYTE             = 8'hD5;
    localparam logic [31:0] CRC_POLY             = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT             = 32'hFFFFFFFF;

    typedef struct packed {
        logic       er;
        logic       en;
        logic [7:0] d;
    } gmii_tx_t;
endpackage

module eth_tx_framer
    import ethernet_pkg::*;
#(
    parameter int unsigned IFG_BYTES       = 12,
    parameter int unsigned MIN_FRAME_BYTES = 60,
    parameter int unsigned MAX_FRAME_BYTES = N_OF_BYTE_FRAME_MAX - N_OF_BYTE_FCS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       busy,
    output logic       underrun,
    output logic       oversize
);

    localparam int unsigned BW      = FRAME_SIZE_BIT_WIDTH;
    localparam int unsigned CW      = 8;
    localparam int unsigned PRE_LEN = 7;

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, IFG} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [BW-1:0]   byte_nxt;
    logic [31:0]     crc_q, crc_d;
    logic [31:0]     fcs_word;
    gmii_tx_t        tx_q, tx_d;
    logic            s_ready_q, s_ready_d;
    logic            busy_q, busy_d;
    logic            underrun_q, underrun_d;
    logic            oversize_q, oversize_d;

    // Reflected CRC-32, one byte folded LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign byte_nxt = byte_cnt_q + BW'(1);
    assign fcs_word = ~crc_q;

    // Outputs are computed for the next cycle and registered with the state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        tx_d       = '0;
        s_ready_d  = 1'b0;
        underrun_d = 1'b0;
        oversize_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    state_d = PREAMBLE;
                    cnt_d   = '0;
                    tx_d    = '{er: 1'b0, en: 1'b1, d: PREAMBLE_BYTE};
                end
            end
            PREAMBLE: begin
                if (cnt_q == CW'(PRE_LEN - 1)) begin
                    state_d   = SFD;
                    tx_d      = '{er: 1'b0, en: 1'b1, d: SFD_BYTE};
                    s_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    tx_d  = '{er: 1'b0, en: 1'b1, d: PREAMBLE_BYTE};
                end
            end
            SFD, DATA: begin
                cnt_d = '0;
                if (s_valid) begin
                    tx_d       = '{er: 1'b0, en: 1'b1, d: s_data};
                    crc_d      = crc_byte(crc_q, s_data);
                    byte_cnt_d = byte_nxt;
                    state_d    = DATA;
                    s_ready_d  = 1'b1;
                    if (s_last) begin
                        s_ready_d = 1'b0;
                        state_d   = FCS;
`ifdef ETH_TX_PAD_EN
                        if (byte_nxt < BW'(MIN_FRAME_BYTES)) state_d = PAD;
`endif
                    end else if (byte_nxt == BW'(MAX_FRAME_BYTES)) begin
                        oversize_d = 1'b1;
                        state_d    = DRAIN;
                    end
                end else begin
                    // Source starved mid-frame: poison the frame and skip the FCS.
                    tx_d       = '{er: 1'b1, en: 1'b1, d: 8'h00};
                    underrun_d = 1'b1;
                    state_d    = IFG;
                end
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
                tx_d       = '{er: 1'b0, en: 1'b1, d: 8'h00};
                crc_d      = crc_byte(crc_q, 8'h00);
                byte_cnt_d = byte_nxt;
                if (byte_nxt == BW'(MIN_FRAME_BYTES)) state_d = FCS;
            end
`endif
            FCS: begin
                tx_d = '{er: 1'b0, en: 1'b1, d: fcs_word[{cnt_q[1:0], 3'b000} +: 8]};
                if (cnt_q == CW'(N_OF_BYTE_FCS - 1)) begin
                    state_d = IFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                s_ready_d = 1'b1;
                // First drain cycle follows the truncation and carries the error marker.
                if (oversize_q) tx_d = '{er: 1'b1, en: 1'b1, d: 8'h00};
                if (s_valid && s_last) begin
                    state_d   = IFG;
                    s_ready_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            IFG: begin
                if (cnt_q == CW'(IFG_BYTES - 1)) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    crc_d      = CRC_INIT;
                    byte_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            crc_q      <= CRC_INIT;
            tx_q       <= '0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            oversize_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            tx_q       <= tx_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            oversize_q <= oversize_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign gmii_txd   = tx_q.d;
    assign gmii_tx_en = tx_q.en;
    assign gmii_tx_er = tx_q.er;
    assign busy       = busy_q;
    assign underrun   = underrun_q;
    assign oversize   = oversize_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: random and directed frames compared with a frame-level reference model.
module tb_eth_tx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       busy;
    logic       underrun;
    logic       oversize;

    eth_tx_framer dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .gmii_txd   (gmii_txd),
        .gmii_tx_en (gmii_tx_en),
        .gmii_tx_er (gmii_tx_er),
        .busy       (busy),
        .underrun   (underrun),
        .oversize   (oversize)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] frame_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] cap[$];
    int         gaps[$];
    int         low_run = 0;
    bit         prev_en = 1'b0;
    bit         seen_frame = 1'b0;
    int         under_cnt = 0;
    int         over_cnt = 0;
    int         un_at = -1;
    int         ov_at = -1;
    bit         chk_win = 1'b0;
    int         ready_viol = 0;

    // Wire monitor: collects transmitted bytes, idle gaps and status pulses.
    always @(negedge clk) begin
        if (gmii_tx_en) begin
            cap.push_back({gmii_tx_er, gmii_txd});
            if (!prev_en && seen_frame) gaps.push_back(low_run);
            seen_frame = 1'b1;
            low_run    = 0;
        end else begin
            low_run++;
        end
        prev_en = gmii_tx_en;
        if (underrun) begin under_cnt++; un_at = cap.size(); end
        if (oversize) begin over_cnt++;  ov_at = cap.size(); end
        if (chk_win && s_ready) ready_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input logic [7:0] d[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ d[i][b]) c = (c >> 1) ^ 32'hEDB88320;
                else                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Expected wire image of the frame in frame_q (or of its first 'keep' bytes plus an error byte).
    task automatic build_exp(input bit err_end, input int keep);
        logic [7:0]  body[$];
        logic [31:0] fcs;
        repeat (7) exp_q.push_back({1'b0, 8'hAA});
        exp_q.push_back({1'b0, 8'hD5});
        if (err_end) begin
            for (int i = 0; i < keep; i++) exp_q.push_back({1'b0, frame_q[i]});
            exp_q.push_back({1'b1, 8'h00});
            return;
        end
        body = frame_q;
`ifdef ETH_TX_PAD_EN
        while (body.size() < 60) body.push_back(8'h00);
`endif
        fcs = ~crc_model(body);
        foreach (body[i]) exp_q.push_back({1'b0, body[i]});
        for (int b = 0; b < 4; b++) exp_q.push_back({1'b0, fcs[8*b +: 8]});
    endtask

    task automatic gen(input int n);
        frame_q.delete();
        repeat (n) frame_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic clr();
        cap.delete(); gaps.delete(); exp_q.delete();
        seen_frame = 1'b0; low_run = 0; under_cnt = 0; over_cnt = 0;
        un_at = -1; ov_at = -1; ready_viol = 0;
    endtask

    task automatic drive(input int n, input bit with_last);
        int k;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = frame_q[i];
            s_last  = with_last && (i == n - 1);
            k = 0;
            @(negedge clk);
            while (!s_ready && k < 200) begin @(negedge clk); k++; end
            if (k >= 200) begin
                chk("drive_stall", 32'(s_ready), 32'd1);
                s_valid = 1'b0; s_last = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 6000) begin @(negedge clk); k++; end
        chk("busy_drop", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic cmp(input string tag);
        int bad = -1;
        int n;
        chk({tag, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (bad < 0 && cap[i] !== exp_q[i]) bad = i;
        end
        if (bad >= 0) $display("  first diff at %0d: got %0h want %0h", bad, cap[bad], exp_q[bad]);
        chk({tag, "_bad_idx"}, 32'(bad), 32'hFFFFFFFF);
    endtask

    function automatic int last_gap();
        return (gaps.size() > 0) ? gaps[gaps.size() - 1] : -1;
    endfunction

    initial begin
        int lens[4] = '{1, 59, 60, 61};
        int na, nb;
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txd",      32'(gmii_txd),   32'd0);
        chk("rst_tx_en",    32'(gmii_tx_en), 32'd0);
        chk("rst_tx_er",    32'(gmii_tx_er), 32'd0);
        chk("rst_s_ready",  32'(s_ready),    32'd0);
        chk("rst_busy",     32'(busy),       32'd0);
        chk("rst_underrun", 32'(underrun),   32'd0);
        chk("rst_oversize", 32'(oversize),   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Known vector "123456789"
        clr();
        frame_q.delete();
        for (int i = 0; i < 9; i++) frame_q.push_back(8'(8'h31 + i));
        build_exp(1'b0, 0);
        drive(9, 1'b1);
        wait_idle();
        cmp("vec9");
`ifndef ETH_TX_PAD_EN
        chk("vec9_fcs", {23'd0, cap[cap.size()-4][7:0], cap[cap.size()-3][0]} , {23'd0, 8'h26, 1'b1});
        chk("vec9_fcs_hi", {cap[cap.size()-3][7:0], cap[cap.size()-2][7:0], cap[cap.size()-1][7:0], 8'h00},
            32'h39F4CB00);
`endif

        // 14-byte frame: padded length when padding is built in
        clr(); gen(14); build_exp(1'b0, 0);
        drive(14, 1'b1); wait_idle();
        cmp("f14");
`ifdef ETH_TX_PAD_EN
        chk("f14_en_cycles", 32'(cap.size()), 32'd72);
`else
        chk("f14_en_cycles", 32'(cap.size()), 32'd26);
`endif

        // Pad boundary lengths, then random lengths
        foreach (lens[j]) begin
            clr(); gen(lens[j]); build_exp(1'b0, 0);
            drive(lens[j], 1'b1); wait_idle();
            cmp($sformatf("len%0d", lens[j]));
        end
        repeat (4) begin
            na = $urandom_range(1, 120);
            clr(); gen(na); build_exp(1'b0, 0);
            drive(na, 1'b1); wait_idle();
            cmp($sformatf("rnd%0d", na));
        end

        // Back-to-back frames: exact inter-frame gap
        clr();
        na = $urandom_range(20, 80); gen(na); build_exp(1'b0, 0); drive(na, 1'b1);
        nb = $urandom_range(1, 80);  gen(nb); build_exp(1'b0, 0); drive(nb, 1'b1);
        wait_idle();
        cmp("b2b");
        chk("b2b_gap", 32'(last_gap()), 32'd12);

        // Maximum legal frame
        clr(); gen(1522); build_exp(1'b0, 0);
        drive(1522, 1'b1);
        chk_win = 1'b1;
        wait_idle();
        chk_win = 1'b0;
        cmp("max");
        chk("max_en_cycles", 32'(cap.size()), 32'd1534);
        chk("max_ready_low", 32'(ready_viol), 32'd0);

        // Underrun after byte 20, next frame queued immediately
        clr(); gen(20); build_exp(1'b1, 20);
        drive(20, 1'b0);
        @(posedge clk); #1;
        nb = $urandom_range(1, 64); gen(nb); build_exp(1'b0, 0);
        drive(nb, 1'b1); wait_idle();
        cmp("underrun");
        chk("underrun_pulses", 32'(under_cnt), 32'd1);
        chk("underrun_at",     32'(un_at),     32'd29);
        chk("underrun_gap",    32'(last_gap()), 32'd12);

        // Oversize: truncated at 1522, rest drained silently
        clr(); gen(1530); build_exp(1'b1, 1522);
        drive(1530, 1'b1); wait_idle();
        cmp("oversize");
        chk("oversize_pulses", 32'(over_cnt), 32'd1);
        chk("oversize_at",     32'(ov_at),    32'd1530);

        // Reset asserted mid-DATA
        clr();
        s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx_en",   32'(gmii_tx_en), 32'd0);
        chk("mid_rst_txd",     32'(gmii_txd),   32'd0);
        chk("mid_rst_busy",    32'(busy),       32'd0);
        chk("mid_rst_s_ready", 32'(s_ready),    32'd0);
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        clr(); na = $urandom_range(1, 70); gen(na); build_exp(1'b0, 0);
        drive(na, 1'b1); wait_idle();
        cmp("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
